mem_req_sequencer: RTL
======================

// Module: mem_req_sequencer
// PURPOSE
//  Upstream front end of the cache/memory model. Accepts one load/store at a time from a core over
//  a valid/ready handshake, drives address/write_en/write_data into the cache hierarchy, samples the
//  L1D/L2 hit flags, and holds the response for a level-dependent modelled latency. Keeps hit/miss
//  statistics so the simulated hierarchy produces cycle-approximate timing.
// PARAMETERS
//  DATA_WIDTH  32  data word width
//  ADDR_WIDTH  8   word address width
//  L1_LAT      1   cycles charged for an L1D read hit (>=1)
//  L2_LAT      4   cycles charged for an L1D miss / L2 hit read (>=1)
//  MM_LAT      20  cycles charged for a main-memory read and for every write (write-through) (>=1)
//  CNT_WIDTH   32  width of each statistics counter
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           reset, asynchronous, active-low
//  req_valid      in   1           core request valid
//  req_ready      out  1           sequencer can accept a request
//  req_we         in   1           1=store, 0=load
//  req_addr       in   ADDR_WIDTH  request address
//  req_wdata      in   DATA_WIDTH  store data
//  resp_valid     out  1           response valid
//  resp_ready     in   1           core accepts response
//  resp_rdata     out  DATA_WIDTH  load data (store: echo of written data)
//  cm_write_en    out  1           write enable to cache model
//  cm_address     out  ADDR_WIDTH  address to cache model
//  cm_write_data  out  DATA_WIDTH  write data to cache model
//  cm_read_data   in   DATA_WIDTH  read data from cache model (valid same cycle as address)
//  cm_l1_hit      in   1           L1D hit flag from cache model
//  cm_l2_hit      in   1           L2 hit flag from cache model
//  stat_clr       in   1           synchronous clear of all statistics counters
//  stat_l1_hits   out  CNT_WIDTH   reads served by L1D
//  stat_l2_hits   out  CNT_WIDTH   reads served by L2
//  stat_mm_reads  out  CNT_WIDTH   reads served by main memory
//  stat_writes    out  CNT_WIDTH   writes issued
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; req_ready=0 while rst low; resp_valid=0, resp_rdata=0,
//    cm_write_en=0, cm_address=0, cm_write_data=0, all counters=0. Mid-transaction reset aborts it
//    with no write issued after rst falls; no response is produced.
//  - FSM IDLE -> LOOKUP -> WAIT -> RESP -> IDLE. req_ready=1 only in IDLE (rst high).
//  - IDLE: on req_valid&req_ready latch we/addr/wdata; next state LOOKUP.
//  - LOOKUP (exactly 1 cycle): cm_address=latched addr; cm_write_data=latched wdata;
//    cm_write_en=latched we for this cycle only (0 in every other state). Select lat:
//    write -> MM_LAT; read & cm_l1_hit -> L1_LAT; read & ~l1 & cm_l2_hit -> L2_LAT; else MM_LAT.
//    Capture cm_read_data (read) or latched wdata (write) into resp_rdata. Load down-counter with
//    lat-1; next state RESP if lat-1==0 else WAIT. Increment exactly one statistics counter.
//  - WAIT: decrement each cycle; at count 1 -> RESP next. Inputs cm_* ignored.
//  - RESP: resp_valid=1, resp_rdata stable; on resp_ready -> IDLE. Backpressure holds indefinitely.
//  - Latency: handshake in cycle T -> resp_valid first high in cycle T+1+lat. Next request accepted
//    no earlier than the cycle after the response handshake (one outstanding request, no overlap).
//  - cm_address holds last value outside LOOKUP; req_* changes after handshake are ignored.
//  - Counters saturate at all-ones (no wrap). stat_clr wins over a same-cycle increment.
//  - L2 hit flag is ignored when L1 hit is set (L1 has priority).
// TESTING
//  1 Read, cm_l1_hit=1, data 0xDEADBEEF at addr 0x10 -> resp_valid at T+2, rdata 0xDEADBEEF, l1_hits=1.
//  2 Read, l1=0,l2=1 -> resp_valid at T+5 (L2_LAT=4); l1=0,l2=0 -> T+21; l2_hits=1, mm_reads=1.
//  3 Write 0x12345678 to 0x20 -> cm_write_en high one cycle (T+1) with addr 0x20; resp at T+21 echoing 0x12345678; writes=1.
//  4 Hold resp_ready=0 for 10 cycles -> resp_valid/rdata stable, req_ready=0; release -> IDLE, next req accepted.
//  5 Pull rst low during WAIT of an MM read -> all outputs 0 immediately; after release req_ready=1, no stale resp.
//  6 Force counter to all-ones then one more L1 hit -> stays all-ones; stat_clr with same-cycle hit -> 0.

Source files
------------

// File: rtl/mem_req_sequencer.sv
// Front end between a core and the cache model: one outstanding load/store, level-dependent
// response latency, and saturating hit/miss statistics.
module mem_req_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int L1_LAT     = 1,
    parameter int L2_LAT     = 4,
    parameter int MM_LAT     = 20,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  cm_write_en,
    output logic [ADDR_WIDTH-1:0] cm_address,
    output logic [DATA_WIDTH-1:0] cm_write_data,
    input  logic [DATA_WIDTH-1:0] cm_read_data,
    input  logic                  cm_l1_hit,
    input  logic                  cm_l2_hit,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  stat_l1_hits,
    output logic [CNT_WIDTH-1:0]  stat_l2_hits,
    output logic [CNT_WIDTH-1:0]  stat_mm_reads,
    output logic [CNT_WIDTH-1:0]  stat_writes,
    output logic [1:0]            dbg_state
);

    // Both handshakes are plain valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; the sender holds its payload stable until that edge.

    localparam int MAX_LAT_12 = (L1_LAT > L2_LAT) ? L1_LAT : L2_LAT;
    localparam int MAX_LAT    = (MAX_LAT_12 > MM_LAT) ? MAX_LAT_12 : MM_LAT;
    localparam int LAT_W      = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [LAT_W-1:0]      r_cnt;
    logic [CNT_WIDTH-1:0]  r_l1_hits;
    logic [CNT_WIDTH-1:0]  r_l2_hits;
    logic [CNT_WIDTH-1:0]  r_mm_reads;
    logic [CNT_WIDTH-1:0]  r_writes;

    logic                  w_accept;
    logic                  w_lookup;
    logic [LAT_W-1:0]      w_lat;
    logic                  w_sel_l1;
    logic                  w_sel_l2;
    logic                  w_sel_mm;
    logic                  w_sel_wr;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign req_ready     = rst && (r_state == S_IDLE);
    assign w_accept      = req_valid && req_ready;
    assign w_lookup      = (r_state == S_LOOKUP);
    assign resp_valid    = (r_state == S_RESP);
    assign resp_rdata    = r_rdata;
    assign cm_write_en   = w_lookup && r_we;
    assign cm_address    = r_addr;
    assign cm_write_data = r_wdata;
    assign stat_l1_hits  = r_l1_hits;
    assign stat_l2_hits  = r_l2_hits;
    assign stat_mm_reads = r_mm_reads;
    assign stat_writes   = r_writes;
    assign dbg_state     = r_state;

    // L1 hit takes priority over L2; writes always pay main-memory latency (write-through).
    always_comb begin
        w_sel_l1 = 1'b0;
        w_sel_l2 = 1'b0;
        w_sel_mm = 1'b0;
        w_sel_wr = 1'b0;
        w_lat    = LAT_W'(MM_LAT);
        if (r_we) begin
            w_sel_wr = w_lookup;
        end else if (cm_l1_hit) begin
            w_sel_l1 = w_lookup;
            w_lat    = LAT_W'(L1_LAT);
        end else if (cm_l2_hit) begin
            w_sel_l2 = w_lookup;
            w_lat    = LAT_W'(L2_LAT);
        end else begin
            w_sel_mm = w_lookup;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOOKUP;
            S_LOOKUP: w_next = (w_lat == LAT_W'(1)) ? S_RESP : S_WAIT;
            S_WAIT:   if (r_cnt == LAT_W'(1)) w_next = S_RESP;
            S_RESP:   if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Response data and the latency count are both fixed in the single LOOKUP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_cnt   <= '0;
        end else if (w_lookup) begin
            r_rdata <= r_we ? r_wdata : cm_read_data;
            r_cnt   <= w_lat - LAT_W'(1);
        end else if (r_state == S_WAIT) begin
            r_cnt   <= r_cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_l1_hits  <= '0;
            r_l2_hits  <= '0;
            r_mm_reads <= '0;
            r_writes   <= '0;
        end else if (stat_clr) begin
            r_l1_hits  <= '0;
            r_l2_hits  <= '0;
            r_mm_reads <= '0;
            r_writes   <= '0;
        end else begin
            r_l1_hits  <= sat_inc(r_l1_hits, w_sel_l1);
            r_l2_hits  <= sat_inc(r_l2_hits, w_sel_l2);
            r_mm_reads <= sat_inc(r_mm_reads, w_sel_mm);
            r_writes   <= sat_inc(r_writes, w_sel_wr);
        end
    end

endmodule
